block_drop_ctrl: RTL and testbench
==================================

Name: block_drop_ctrl

Overview:
- Game sequencer for the 8x8 falling-blocks game.
- Owns the 64-bit `blocks` field and the 8-bit one-hot `aim` cursor that feed the judge/display path.
- On each drop tick it scrolls rows toward row 0 and spawns a pseudo-random top row.
- It then checks the bottom row against `aim` to raise game-over or score a survived row.

Parameters:
- TICK_DIV, 25000000, clk cycles per drop tick in PLAY (bench overrides to 4); must be >=8.
- LFSR_SEED, 16'hACE1, reset/start value of row-generator LFSR; must be nonzero.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; begins or restarts a game from IDLE or OVER
- left  input  1  single-cycle pulse; move aim one column toward bit 7
- right  input  1  single-cycle pulse; move aim one column toward bit 0
- blocks  output  64  field; row r = bits[8r+7:8r], row 0 = bottom
- aim  output  8  one-hot player column in bottom row
- gameover  output  1  high while in OVER
- score  output  16  rows survived, binary, saturating
- busy  output  1  high in PLAY/SHIFT/CHECK

Behaviour:
- Reset (rst=0, async), all registers take these values immediately:
  - blocks=0, aim=8'h10, gameover=0, score=0, busy=0
  - state=IDLE, tick counter=0, period=TICK_DIV, lfsr=LFSR_SEED
- Reset mid-operation in any state behaves identically; no partial shift or score update survives.
- States: IDLE, PLAY, SHIFT, CHECK, OVER.
- IDLE or OVER with start=1:
  - next cycle: blocks=0, score=0, gameover=0, aim=8'h10, counter=0, lfsr=LFSR_SEED, state=PLAY.
  - left/right are ignored in these states.
- PLAY:
  - Counter increments each cycle.
  - When counter==period-1: counter<=0 and state<=SHIFT. The drop period is therefore exactly `period` PLAY cycles.
- Movement (PLAY only):
  - left: aim<=aim<<1 unless aim[7]=1 (saturate) or target cell blocks[7:0]&(aim<<1) is nonzero (blocked).
  - right: symmetric using >>1 and aim[0].
  - left and right in the same cycle: no move.
  - Moves in SHIFT/CHECK are dropped, not queued.
- SHIFT (1 cycle):
  - blocks<={newrow, blocks[63:8]} (bottom row discarded).
  - newrow = lfsr[7:0] & lfsr[15:8]; if that equals 8'hFF, use 8'h7F instead.
  - LFSR advances one step: Galois, right shift, XOR mask 16'hB400 when the shifted-out bit is 1.
  - Next state CHECK.
- CHECK (1 cycle), using the post-shift blocks:
  - If blocks[7:0]&aim != 0: gameover<=1, state<=OVER, score unchanged.
  - Else: score<=score+1 (saturates at 16'hFFFF), state<=PLAY.
- Latency: blocks change 1 cycle after the tick, gameover/score 2 cycles after.
- OVER: blocks, aim and score held frozen for display; busy=0.
- start while busy is ignored.

Optional Feature:
SPEEDUP_EN
- Defined: in CHECK, when the incremented score is a multiple of 16, period<=period>>1, floored at TICK_DIV>>3. Period reloads to TICK_DIV on start and on reset.
- Undefined: period is constant TICK_DIV; no extra logic.

Test Plan:
- Reset: hold rst=0 mid-PLAY -> blocks=0, aim=8'h10, score=0, gameover=0, busy=0 with no clk edge required; release, idle 10 cycles -> unchanged.
- TICK_DIV=4, start pulse -> busy=1 next cycle; SHIFT after 4 PLAY cycles.
  - blocks[55:0]=0 and blocks[63:56] equal to the reference-model newrow from seed ACE1.
  - score=1 two cycles after the tick; repeat 8 drops -> score tracks model exactly.
- Cursor, field empty: left x3 from 8'h10 -> 8'h80; 4th left -> 8'h80; right x7 -> 8'h01; 8th -> 8'h01; left+right together -> unchanged.
- Collision: run until the model predicts a bottom row overlapping aim.
  - gameover=1 exactly in the cycle after that CHECK, and score equals the model count.
  - blocks/aim frozen 20 cycles; start -> blocks=0, score=0, gameover=0.
- Blocked move: the model yields a bottom row with bit 5 set and aim=8'h10 -> left pulse keeps aim=8'h10.
- SPEEDUP_EN defined, TICK_DIV=8: tick spacing 8 cycles for scores 0-15, 4 for 16-31, 2 for 32-47, 1 for 48+; undefined -> always 8.

Source files
------------

// File: rtl/block_drop_ctrl.sv
// block_drop_ctrl: 8x8 falling-blocks sequencer (field scroll, random top row, aim cursor, collision/score)
// Ports: clk; rst (async, active-low); start/left/right one-cycle pulses;
//        blocks[63:0] field (row 0 = bits 7:0 = bottom); aim[7:0] one-hot cursor;
//        gameover (in OVER); score[15:0] saturating; busy (PLAY/SHIFT/CHECK).
// Build option: define SPEEDUP_EN to halve the drop period every 16 points.
module block_drop_ctrl #(
  parameter int          TICK_DIV  = 25000000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        left,
  input  logic        right,
  output logic [63:0] blocks,
  output logic [7:0]  aim,
  output logic        gameover,
  output logic [15:0] score,
  output logic        busy
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;
  localparam logic [31:0] PERIOD_INIT = 32'(TICK_DIV);

  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d, period_q;
  logic [15:0] lfsr_q, lfsr_d, lfsr_nxt, score_q, score_d, score_inc;
  logic [63:0] blocks_q, blocks_d;
  logic [7:0]  aim_q, aim_d, aim_l, aim_r, raw_row, new_row;
  logic        go_l, go_r, hit, restart, tick;

  // An all-ones row would be unsurvivable, so one gap is forced in column 7.
  assign raw_row   = lfsr_q[7:0] & lfsr_q[15:8];
  assign new_row   = &raw_row ? 8'h7F : raw_row;
  assign lfsr_nxt  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign aim_l     = aim_q << 1;
  assign aim_r     = aim_q >> 1;
  assign go_l      = left & ~right & ~aim_q[7] & ~|(blocks_q[7:0] & aim_l);
  assign go_r      = right & ~left & ~aim_q[0] & ~|(blocks_q[7:0] & aim_r);
  assign hit       = |(blocks_q[7:0] & aim_q);
  assign score_inc = &score_q ? score_q : score_q + 16'd1;
  assign restart   = start & (state_q == S_IDLE | state_q == S_OVER);
  assign tick      = cnt_q == period_q - 32'd1;

`ifdef SPEEDUP_EN
  localparam logic [31:0] PERIOD_MIN = PERIOD_INIT >> 3;
  logic [31:0] period_d, period_half;
  assign period_half = period_q >> 1;
  always_comb begin
    period_d = period_q;
    if (restart)
      period_d = PERIOD_INIT;
    else if (state_q == S_CHECK && !hit && score_inc[3:0] == 4'h0)
      period_d = period_half < PERIOD_MIN ? PERIOD_MIN : period_half;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) period_q <= PERIOD_INIT;
    else      period_q <= period_d;
`else
  assign period_q = PERIOD_INIT;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    blocks_d = blocks_q;
    aim_d    = aim_q;
    score_d  = score_q;
    if (restart) begin
      state_d  = S_PLAY;
      cnt_d    = 32'd0;
      lfsr_d   = LFSR_SEED;
      blocks_d = 64'd0;
      aim_d    = 8'h10;
      score_d  = 16'd0;
    end else if (state_q == S_PLAY) begin
      cnt_d   = tick ? 32'd0 : cnt_q + 32'd1;
      state_d = tick ? S_SHIFT : S_PLAY;
      aim_d   = go_l ? aim_l : go_r ? aim_r : aim_q;
    end else if (state_q == S_SHIFT) begin
      blocks_d = {new_row, blocks_q[63:8]};
      lfsr_d   = lfsr_nxt;
      state_d  = S_CHECK;
    end else if (state_q == S_CHECK) begin
      state_d = hit ? S_OVER : S_PLAY;
      score_d = hit ? score_q : score_inc;
    end else if (state_q > S_OVER) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 32'd0;
      lfsr_q   <= LFSR_SEED;
      blocks_q <= 64'd0;
      aim_q    <= 8'h10;
      score_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      blocks_q <= blocks_d;
      aim_q    <= aim_d;
      score_q  <= score_d;
    end

  assign blocks   = blocks_q;
  assign aim      = aim_q;
  assign score    = score_q;
  assign gameover = state_q == S_OVER;
  assign busy     = state_q == S_PLAY | state_q == S_SHIFT | state_q == S_CHECK;
endmodule

// File: tb/tb_block_drop_ctrl.sv
// tb_block_drop_ctrl: directed bench for block_drop_ctrl with TICK_DIV=4
module tb_block_drop_ctrl;
  logic        clk = 1'b0, rst, start, left, right;
  logic [63:0] blocks;
  logic [7:0]  aim;
  logic        gameover, busy;
  logic [15:0] score;
  int errs = 0, checks = 0;
  logic [63:0] m_blocks;
  logic [15:0] m_lfsr, m_score;
  logic [7:0]  m_aim;

  block_drop_ctrl #(.TICK_DIV(4), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .left(left), .right(right),
    .blocks(blocks), .aim(aim), .gameover(gameover), .score(score), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic m_start();
    m_blocks = 64'd0;
    m_lfsr   = 16'hACE1;
    m_score  = 16'd0;
    m_aim    = 8'h10;
  endtask

  task automatic m_drop();
    logic [7:0] nr;
    nr = m_lfsr[7:0] & m_lfsr[15:8];
    if (nr == 8'hFF) nr = 8'h7F;
    m_blocks = {nr, m_blocks[63:8]};
    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    if ((m_blocks[7:0] & m_aim) == 8'h00 && m_score != 16'hFFFF) m_score = m_score + 16'd1;
  endtask

  task automatic play4(input logic [3:0] l, input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      left = l[i];
      right = r[i];
      cyc();
    end
    left = 1'b0;
    right = 1'b0;
  endtask

  task automatic drop(input logic [3:0] l, input logic [3:0] r, input logic lsc);
    play4(l, r);
    left = lsc;
    cyc();
    cyc();
    left = 1'b0;
    m_drop();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    pulse_start();
    m_start();
    drop(4'b0001, 4'b0000, 1'b0);
    checks++; if (aim !== 8'h20) begin errs++; $display("FAIL reset_pre_aim: got %h want 20", aim); end
    checks++; if (score !== 16'd1) begin errs++; $display("FAIL reset_pre_score: got %0d want 1", score); end
    repeat (2) cyc();
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL reset_pre_busy: got %b want 1", busy); end
    rst = 1'b0;
    #2;
    checks++; if (blocks !== 64'd0) begin errs++; $display("FAIL reset_blocks: got %h want 0", blocks); end
    checks++; if (aim !== 8'h10) begin errs++; $display("FAIL reset_aim: got %h want 10", aim); end
    checks++; if (score !== 16'd0) begin errs++; $display("FAIL reset_score: got %0d want 0", score); end
    checks++; if (gameover !== 1'b0) begin errs++; $display("FAIL reset_gameover: got %b want 0", gameover); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    #2;
    rst = 1'b1;
    repeat (10) cyc();
    checks++; if (blocks !== 64'd0) begin errs++; $display("FAIL idle_blocks: got %h want 0", blocks); end
    checks++; if (aim !== 8'h10) begin errs++; $display("FAIL idle_aim: got %h want 10", aim); end
    checks++; if (score !== 16'd0) begin errs++; $display("FAIL idle_score: got %0d want 0", score); end
    checks++; if ({busy, gameover} !== 2'b00) begin errs++; $display("FAIL idle_flags: got %b want 00", {busy, gameover}); end
  endtask

  task automatic test_start_drop();
    pulse_start();
    m_start();
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL start_busy: got %b want 1", busy); end
    play4(4'b0000, 4'b0000);
    checks++; if (blocks !== 64'd0) begin errs++; $display("FAIL pre_tick_blocks: got %h want 0", blocks); end
    cyc();
    checks++; if (blocks !== 64'hA000_0000_0000_0000) begin errs++; $display("FAIL shift_blocks: got %h want a000000000000000", blocks); end
    checks++; if (score !== 16'd0) begin errs++; $display("FAIL shift_score: got %0d want 0", score); end
    cyc();
    m_drop();
    checks++; if (score !== 16'd1) begin errs++; $display("FAIL check_score: got %0d want 1", score); end
    checks++; if ({busy, gameover} !== 2'b10) begin errs++; $display("FAIL check_flags: got %b want 10", {busy, gameover}); end
    checks++; if (blocks !== m_blocks) begin errs++; $display("FAIL check_blocks: got %h want %h", blocks, m_blocks); end
  endtask

  task automatic test_cursor();
    drop(4'b0111, 4'b0000, 1'b0);
    m_aim = 8'h80;
    checks++; if (aim !== 8'h80) begin errs++; $display("FAIL left3: got %h want 80", aim); end
    drop(4'b0001, 4'b0000, 1'b0);
    checks++; if (aim !== 8'h80) begin errs++; $display("FAIL left_sat: got %h want 80", aim); end
    drop(4'b0000, 4'b1111, 1'b0);
    checks++; if (aim !== 8'h08) begin errs++; $display("FAIL right4: got %h want 08", aim); end
    drop(4'b0000, 4'b0111, 1'b0);
    m_aim = 8'h01;
    checks++; if (aim !== 8'h01) begin errs++; $display("FAIL right7: got %h want 01", aim); end
    drop(4'b0001, 4'b0011, 1'b0);
    checks++; if (aim !== 8'h01) begin errs++; $display("FAIL both_and_right_sat: got %h want 01", aim); end
    drop(4'b0000, 4'b0000, 1'b1);
    checks++; if (aim !== 8'h01) begin errs++; $display("FAIL move_in_shift: got %h want 01", aim); end
    checks++; if (score !== 16'd7) begin errs++; $display("FAIL cursor_score: got %0d want 7", score); end
  endtask

  task automatic test_collision();
    int n = 0;
    while ((m_blocks[15:8] & m_aim) == 8'h00 && n < 40) begin
      drop(4'b0000, 4'b0000, 1'b0);
      n++;
      checks++; if (score !== m_score || gameover !== 1'b0) begin errs++; $display("FAIL run_drop%0d: got score %0d go %b want %0d 0", n, score, gameover, m_score); end
    end
    checks++; if (n >= 40) begin errs++; $display("FAIL collision_bound: got %0d drops want <40", n); end
    play4(4'b0000, 4'b0000);
    cyc();
    checks++; if (gameover !== 1'b0) begin errs++; $display("FAIL go_early: got %b want 0", gameover); end
    cyc();
    m_drop();
    checks++; if (gameover !== 1'b1) begin errs++; $display("FAIL go_set: got %b want 1", gameover); end
    checks++; if (score !== 16'd13 || m_score !== 16'd13) begin errs++; $display("FAIL go_score: got %0d want 13 (model %0d)", score, m_score); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL go_busy: got %b want 0", busy); end
    for (int i = 0; i < 20; i++) begin
      left = i[0];
      right = ~i[0];
      cyc();
    end
    left = 1'b0;
    right = 1'b0;
    checks++; if (blocks !== m_blocks) begin errs++; $display("FAIL frozen_blocks: got %h want %h", blocks, m_blocks); end
    checks++; if (aim !== 8'h01) begin errs++; $display("FAIL frozen_aim: got %h want 01", aim); end
    checks++; if (score !== 16'd13 || gameover !== 1'b1) begin errs++; $display("FAIL frozen_score: got %0d go %b want 13 1", score, gameover); end
    pulse_start();
    m_start();
    checks++; if (blocks !== 64'd0) begin errs++; $display("FAIL restart_blocks: got %h want 0", blocks); end
    checks++; if (score !== 16'd0 || gameover !== 1'b0) begin errs++; $display("FAIL restart_score: got %0d go %b want 0 0", score, gameover); end
    checks++; if (aim !== 8'h10 || busy !== 1'b1) begin errs++; $display("FAIL restart_aim: got %h busy %b want 10 1", aim, busy); end
  endtask

  task automatic test_blocked();
    repeat (8) drop(4'b0000, 4'b0000, 1'b0);
    checks++; if (score !== 16'd8 || m_score !== 16'd8) begin errs++; $display("FAIL eight_score: got %0d want 8 (model %0d)", score, m_score); end
    checks++; if (blocks !== m_blocks) begin errs++; $display("FAIL eight_blocks: got %h want %h", blocks, m_blocks); end
    checks++; if (blocks[7:0] !== 8'hA0) begin errs++; $display("FAIL bottom_row: got %h want a0", blocks[7:0]); end
    left = 1'b1;
    cyc();
    left = 1'b0;
    checks++; if (aim !== 8'h10) begin errs++; $display("FAIL blocked_left: got %h want 10", aim); end
    right = 1'b1;
    cyc();
    right = 1'b0;
    checks++; if (aim !== 8'h08) begin errs++; $display("FAIL free_right: got %h want 08", aim); end
    left = 1'b1;
    cyc();
    left = 1'b0;
    checks++; if (aim !== 8'h10) begin errs++; $display("FAIL free_left: got %h want 10", aim); end
    pulse_start();
    cyc();
    cyc();
    m_drop();
    checks++; if (score !== 16'd9) begin errs++; $display("FAIL start_while_busy: got %0d want 9", score); end
    checks++; if (blocks !== m_blocks || busy !== 1'b1) begin errs++; $display("FAIL busy_blocks: got %h busy %b want %h 1", blocks, busy, m_blocks); end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    left = 1'b0;
    right = 1'b0;
    m_start();
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    test_reset();
    test_start_drop();
    test_cursor();
    test_collision();
    test_blocked();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
